// File: rtl/uart_cmd_pkg.sv
// Shared constants, types and helpers for the UART command initiator.
package uart_cmd_pkg;

    localparam logic [7:0] CmdA = 8'h41;
    localparam logic [7:0] CmdB = 8'h42;
    localparam logic [7:0] CmdC = 8'h43;
    localparam logic [7:0] CmdZ = 8'h5A;

    localparam logic [7:0] Reply1 = 8'h31;
    localparam logic [7:0] Reply2 = 8'h32;
    localparam logic [7:0] ReplyX = 8'h58;

    typedef enum logic [1:0] {
        RES_PASS     = 2'd0,
        RES_MISMATCH = 2'd1,
        RES_PARITY   = 2'd2,
        RES_TIMEOUT  = 2'd3
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Command select to transmitted byte.
    function automatic logic [7:0] cmdByte(input logic [1:0] sel);
        case (sel)
            2'd0:    cmdByte = CmdA;
            2'd1:    cmdByte = CmdB;
            2'd2:    cmdByte = CmdC;
            default: cmdByte = CmdZ;
        endcase
    endfunction

    // Command byte to the reply the board is expected to return.
    function automatic logic [7:0] expectedReply(input logic [7:0] cmd);
        case (cmd)
            CmdA:    expectedReply = Reply1;
            CmdB:    expectedReply = Reply2;
            default: expectedReply = ReplyX;
        endcase
    endfunction

endpackage

// File: rtl/uart_timeout_counter.sv
// Reply timeout counter: clears to zero, counts while enabled, and pulses
// o_expired for the one cycle in which the count equals termCount-1.
module uart_timeout_counter #(
    parameter int unsigned termCount = 9360
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CntW = (termCount > 2) ? $clog2(termCount) : 1;
    // Expiry is registered one count early so the pulse lines up with count == termCount-1.
    localparam logic [CntW-1:0] PreTerm = CntW'(termCount - 2);

    logic [CntW-1:0] count;

    // Count register and registered expiry pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            o_expired <= 1'b0;
        end else if (i_clear) begin
            count     <= '0;
            o_expired <= 1'b0;
        end else if (i_enable) begin
            count     <= count + CntW'(1);
            o_expired <= (count == PreTerm);
        end else begin
            o_expired <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_initiator.sv
// Sends one command byte, waits for the single-byte reply, retries on parity
// error or timeout, and reports a result code.
module uart_cmd_initiator
    import uart_cmd_pkg::*;
#(
    parameter int unsigned clksPerBit  = 234,
    parameter int unsigned timeoutBits = 40,
    parameter int unsigned maxRetries  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [1:0] i_cmdSel,
    output logic       o_enableTx,
    output logic [7:0] o_bitsTx,
    input  logic       i_txDone,
    input  logic       i_rxFinished,
    input  logic [7:0] i_rxBits,
    input  logic       i_parityError,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_result,
    output logic [7:0] o_rxByte,
    output logic [1:0] o_attempts,
    output logic       o_unexpected
);

    localparam int unsigned TimeoutClks = timeoutBits * clksPerBit;
    localparam logic [1:0]  MaxAttempts = 2'(maxRetries + 1);

    state_t     state, stateNext;
    result_t    resultQ, resultNext;
    logic [7:0] cmdQ, cmdNext;
    logic [7:0] expQ, expNext;
    logic       firstQ, firstNext;
    logic       enableTxNext, doneNext, unexpNext, busyNext;
    logic [7:0] bitsTxNext, rxByteNext;
    logic [1:0] attemptsNext;
    logic       expired;
    logic       retriesLeft;

    // Transmitter completion is informational; the reply timeout runs from SEND.
    logic unusedTxDone;
    assign unusedTxDone = i_txDone;

    assign retriesLeft = (o_attempts < MaxAttempts);
    assign o_result    = 2'(resultQ);

    // Reply timeout, restarted on every transmit.
    uart_timeout_counter #(
        .termCount(TimeoutClks)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (state == ST_SEND),
        .i_enable (state == ST_WAIT_RSP),
        .o_expired(expired)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            resultQ      <= RES_PASS;
            cmdQ         <= 8'h00;
            expQ         <= 8'h00;
            firstQ       <= 1'b0;
            o_enableTx   <= 1'b0;
            o_bitsTx     <= 8'h00;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_rxByte     <= 8'h00;
            o_attempts   <= 2'd0;
            o_unexpected <= 1'b0;
        end else begin
            state        <= stateNext;
            resultQ      <= resultNext;
            cmdQ         <= cmdNext;
            expQ         <= expNext;
            firstQ       <= firstNext;
            o_enableTx   <= enableTxNext;
            o_bitsTx     <= bitsTxNext;
            o_busy       <= busyNext;
            o_done       <= doneNext;
            o_rxByte     <= rxByteNext;
            o_attempts   <= attemptsNext;
            o_unexpected <= unexpNext;
        end
    end

    // Next-state and next-output logic; a received byte beats a same-cycle timeout.
    always_comb begin
        stateNext    = state;
        resultNext   = resultQ;
        cmdNext      = cmdQ;
        expNext      = expQ;
        firstNext    = firstQ;
        enableTxNext = 1'b0;
        bitsTxNext   = o_bitsTx;
        busyNext     = (state != ST_IDLE);
        doneNext     = 1'b0;
        rxByteNext   = o_rxByte;
        attemptsNext = o_attempts;
        unexpNext    = 1'b0;

        case (state)
            ST_IDLE: begin
                unexpNext = i_rxFinished;
                if (i_start) begin
                    cmdNext   = cmdByte(i_cmdSel);
                    expNext   = expectedReply(cmdByte(i_cmdSel));
                    firstNext = 1'b1;
                    stateNext = ST_SEND;
                end
            end
            ST_SEND: begin
                enableTxNext = 1'b1;
                bitsTxNext   = cmdQ;
                firstNext    = 1'b0;
                attemptsNext = firstQ ? 2'd1 : o_attempts + 2'd1;
                stateNext    = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (i_rxFinished) begin
                    if (i_parityError) begin
                        if (retriesLeft) begin
                            stateNext = ST_SEND;
                        end else begin
                            resultNext = RES_PARITY;
                            stateNext  = ST_DONE;
                        end
                    end else begin
                        rxByteNext = i_rxBits;
                        resultNext = (i_rxBits == expQ) ? RES_PASS : RES_MISMATCH;
                        stateNext  = ST_DONE;
                    end
                end else if (expired) begin
                    if (retriesLeft) begin
                        stateNext = ST_SEND;
                    end else begin
                        resultNext = RES_TIMEOUT;
                        stateNext  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                doneNext  = 1'b1;
                unexpNext = i_rxFinished;
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Scoreboard bench for uart_cmd_initiator: stimulus queues expected transmits,
// completions and stray-byte pulses; a monitor pops and compares them.
module tb_uart_cmd_initiator;

    localparam int unsigned ClksPerBit  = 234;
    localparam int unsigned TimeoutBits = 40;
    localparam int unsigned MaxRetries  = 2;
    localparam int          T           = ClksPerBit * TimeoutBits;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [1:0] i_cmdSel;
    logic       o_enableTx;
    logic [7:0] o_bitsTx;
    logic       i_txDone;
    logic       i_rxFinished;
    logic [7:0] i_rxBits;
    logic       i_parityError;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_result;
    logic [7:0] o_rxByte;
    logic [1:0] o_attempts;
    logic       o_unexpected;

    typedef struct {
        logic [1:0] res;
        logic [7:0] rx;
        logic [1:0] att;
    } doneExp_t;

    logic [7:0] expTx[$];
    doneExp_t   expDone[$];
    int         pendingUnexp = 0;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         monOn = 0;
    logic [7:0] monTx;
    doneExp_t   monD;

    uart_cmd_initiator #(
        .clksPerBit (ClksPerBit),
        .timeoutBits(TimeoutBits),
        .maxRetries (MaxRetries)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_cmdSel     (i_cmdSel),
        .o_enableTx   (o_enableTx),
        .o_bitsTx     (o_bitsTx),
        .i_txDone     (i_txDone),
        .i_rxFinished (i_rxFinished),
        .i_rxBits     (i_rxBits),
        .i_parityError(i_parityError),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_rxByte     (o_rxByte),
        .o_attempts   (o_attempts),
        .o_unexpected (o_unexpected)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each DUT output event with the head of its queue.
    always @(negedge clk) begin
        if (monOn) begin
            if (o_enableTx === 1'b1) begin
                if (expTx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spuriousTx: got bitsTx=0x%0h, no transmit expected", o_bitsTx);
                end else begin
                    monTx = expTx.pop_front();
                    check("txByte", 32'(o_bitsTx), 32'(monTx));
                end
            end
            if (o_done === 1'b1) begin
                if (expDone.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spuriousDone: got result=%0d, no completion expected", o_result);
                end else begin
                    monD = expDone.pop_front();
                    check("doneResult", 32'(o_result), 32'(monD.res));
                    check("doneRxByte", 32'(o_rxByte), 32'(monD.rx));
                    check("doneAttempts", 32'(o_attempts), 32'(monD.att));
                end
            end
            if (o_unexpected === 1'b1) begin
                checks++;
                if (pendingUnexp == 0) begin
                    errors++;
                    $display("FAIL spuriousUnexpected: got pulse, none expected");
                end else begin
                    pendingUnexp--;
                end
            end
        end
    end

    task automatic startCmd(input logic [1:0] sel);
        @(negedge clk);
        i_start  = 1'b1;
        i_cmdSel = sel;
        @(negedge clk);
        i_start  = 1'b0;
    endtask

    task automatic waitTx(output int when);
        bit found = 0;
        when = -1;
        for (int i = 0; i < T + 10 && !found; i++) begin
            @(negedge clk);
            if (o_enableTx === 1'b1) begin
                found = 1;
                when  = cyc;
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL txTimeout: got no o_enableTx, expected one within %0d cycles", T + 10);
        end
    endtask

    task automatic waitDone();
        bit found = 0;
        for (int i = 0; i < 4 * T && !found; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) found = 1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL doneTimeout: got no o_done, expected one within %0d cycles", 4 * T);
        end
    endtask

    // Byte from the receiver, sampled at the (d+1)th posedge after the current negedge.
    task automatic sendReply(input logic [7:0] b, input logic par, input int d);
        repeat (d) @(negedge clk);
        i_rxFinished  = 1'b1;
        i_rxBits      = b;
        i_parityError = par;
        @(negedge clk);
        i_rxFinished  = 1'b0;
        i_parityError = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_enableTx"}, 32'(o_enableTx), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_unexpected"}, 32'(o_unexpected), 0);
        check({tag, "_bitsTx"}, 32'(o_bitsTx), 0);
        check({tag, "_result"}, 32'(o_result), 0);
        check({tag, "_rxByte"}, 32'(o_rxByte), 0);
        check({tag, "_attempts"}, 32'(o_attempts), 0);
    endtask

    initial begin
        int t0, t1, t2;
        rst_n = 1'b0; i_start = 1'b0; i_cmdSel = 2'd0; i_txDone = 1'b0;
        i_rxFinished = 1'b0; i_rxBits = 8'h00; i_parityError = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        monOn = 1;
        repeat (2) @(negedge clk);

        // A -> '1' after 12 bit periods: PASS.
        expTx.push_back(8'h41);
        expDone.push_back('{2'd0, 8'h31, 2'd1});
        startCmd(2'd0);
        waitTx(t0);
        check("busyWhileSending", 32'(o_busy), 1);
        repeat (100) @(negedge clk);
        i_txDone = 1'b1;
        @(negedge clk);
        i_txDone = 1'b0;
        sendReply(8'h31, 1'b0, 12 * ClksPerBit - 101);
        waitDone();
        repeat (10) @(negedge clk);

        // B -> 'X': MISMATCH, no retry.
        expTx.push_back(8'h42);
        expDone.push_back('{2'd1, 8'h58, 2'd1});
        startCmd(2'd1);
        waitTx(t0);
        sendReply(8'h58, 1'b0, 100);
        waitDone();
        repeat (50) @(negedge clk);

        // C: parity error then 'X': retry, PASS on second attempt.
        expTx.push_back(8'h43);
        expTx.push_back(8'h43);
        expDone.push_back('{2'd0, 8'h58, 2'd2});
        startCmd(2'd2);
        waitTx(t0);
        sendReply(8'h58, 1'b1, 50);
        waitTx(t0);
        sendReply(8'h58, 1'b0, 30);
        waitDone();
        repeat (10) @(negedge clk);

        // Z with no reply: three transmits T+1 apart, TIMEOUT; last byte held.
        expTx.push_back(8'h5A);
        expTx.push_back(8'h5A);
        expTx.push_back(8'h5A);
        expDone.push_back('{2'd3, 8'h58, 2'd3});
        startCmd(2'd3);
        waitTx(t0);
        waitTx(t1);
        waitTx(t2);
        check("retryGap1", 32'(t1 - t0), 32'(T + 1));
        check("retryGap2", 32'(t2 - t1), 32'(T + 1));
        waitDone();
        repeat (10) @(negedge clk);

        // Reply on the exact timeout cycle wins: PASS, single transmit.
        expTx.push_back(8'h41);
        expDone.push_back('{2'd0, 8'h31, 2'd1});
        startCmd(2'd0);
        waitTx(t0);
        sendReply(8'h31, 1'b0, T - 1);
        waitDone();
        repeat (5) @(negedge clk);
        check("holdResult", 32'(o_result), 0);
        check("holdRxByte", 32'(o_rxByte), 32'h31);
        check("holdAttempts", 32'(o_attempts), 1);
        check("idleNotBusy", 32'(o_busy), 0);

        // Stray byte in IDLE: pulse only, other outputs untouched.
        pendingUnexp++;
        sendReply(8'h32, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("strayRxByte", 32'(o_rxByte), 32'h31);
        check("strayResult", 32'(o_result), 0);
        check("strayAttempts", 32'(o_attempts), 1);
        check("strayBitsTx", 32'(o_bitsTx), 32'h41);
        check("strayBusy", 32'(o_busy), 0);

        // Reset during WAIT_RSP: back to reset values, late reply is stray, no done.
        expTx.push_back(8'h42);
        startCmd(2'd1);
        waitTx(t0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkResetOutputs("midReset");
        pendingUnexp++;
        sendReply(8'h32, 1'b0, 5);
        repeat (30) @(negedge clk);
        check("midResetRxByte", 32'(o_rxByte), 0);

        repeat (10) @(negedge clk);
        check("txQueueDrained", 32'(expTx.size()), 0);
        check("doneQueueDrained", 32'(expDone.size()), 0);
        check("unexpectedAllSeen", 32'(pendingUnexp), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
